reaction_game_ctrl: RTL and testbench



---
 rtl/reaction_game_ctrl.sv | 124 ++++++++++++
 tb/tb_reaction_game_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl.sv
// Reaction-timer sequencer: random wait, GO lamp, BCD reaction count, highscore.
// Optional false-start detection is enabled by defining REACTION_FALSE_START_EN.
module reaction_game_ctrl #(
  parameter int RAND_W    = 16,
  parameter int DELAY_MIN = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              score_clr,
  input  logic [RAND_W-1:0] rand_val,
  output logic [9:0]        led,
  output logic [15:0]       react_bcd,
  output logic [15:0]       best_bcd,
  output logic              new_best,
  output logic [2:0]        state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] GO    = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  localparam int CW = RAND_W + 1;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  logic [CW-1:0] waitCnt;
  logic [CW-1:0] target;
  logic [CW-1:0] waitNext;
  logic [15:0]   reactInc;

  // Digit-wise increment; the caller never feeds 9999 so no wrap handling.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign waitNext = waitCnt + CW'(1);
  assign reactInc = (react_bcd == BCD_MAX) ? BCD_MAX : bcdInc(react_bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      led       <= 10'h000;
      react_bcd <= 16'h0000;
      best_bcd  <= BCD_MAX;
      new_best  <= 1'b0;
      waitCnt   <= '0;
      target    <= '0;
    end else begin
      new_best <= 1'b0;
      if (start) begin
        state     <= WAIT;
        led       <= 10'h000;
        target    <= CW'(DELAY_MIN) + CW'(rand_val);
        waitCnt   <= '0;
        react_bcd <= 16'h0000;
      end else begin
        case (state)
          IDLE, DONE: ;
          WAIT: begin
`ifdef REACTION_FALSE_START_EN
            if (stop) begin
              state     <= FAULT;
              led       <= 10'h2AA;
              react_bcd <= BCD_MAX;
            end else
`endif
            if (tick) begin
              waitCnt <= waitNext;
              if (waitNext == target) begin
                state <= GO;
                led   <= 10'h3FF;
              end
            end
          end
          GO: begin
            if (stop) begin
              state <= DONE;
              led   <= 10'h001;
              // score_clr owns best_bcd this cycle, so no pulse either
              if ((react_bcd < best_bcd) && !score_clr) begin
                best_bcd <= react_bcd;
                new_best <= 1'b1;
              end
            end else if (tick) begin
              react_bcd <= reactInc;
              if (reactInc == BCD_MAX) begin
                state <= DONE;
                led   <= 10'h001;
              end
            end
          end
`ifdef REACTION_FALSE_START_EN
          FAULT: ;
`endif
          default: begin
            state <= IDLE;
            led   <= 10'h000;
          end
        endcase
      end
      if (score_clr) best_bcd <= BCD_MAX;
    end
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with a decimal-count reference model
// checked every cycle, plus literal checkpoints from the game scenarios.
module tb_reaction_game_ctrl;

  localparam int RW   = 16;
  localparam int DMIN = 4;
`ifdef REACTION_FALSE_START_EN
  localparam bit FSEN = 1'b1;
`else
  localparam bit FSEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, tick, start, stop, score_clr;
  logic [RW-1:0] rand_val;
  logic [9:0]    led;
  logic [15:0]   react_bcd, best_bcd;
  logic          new_best;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;

  reaction_game_ctrl #(.RAND_W(RW), .DELAY_MIN(DMIN)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .score_clr(score_clr), .rand_val(rand_val), .led(led),
    .react_bcd(react_bcd), .best_bcd(best_bcd), .new_best(new_best), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: plain decimal counts, converted to BCD only for comparison.
  int mState, waitLeft, reactN, bestN;
  bit mNewBest, armed = 1'b0;

  function automatic logic [15:0] toBcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [9:0] ledFor(input int s);
    case (s)
      2:       return 10'h3FF;
      3:       return 10'h001;
      4:       return 10'h2AA;
      default: return 10'h000;
    endcase
  endfunction

  always @(posedge clk) begin
    armed    = 1'b1;
    mNewBest = 1'b0;
    if (reset) begin
      mState = 0; waitLeft = 0; reactN = 0; bestN = 9999;
    end else begin
      if (start) begin
        mState = 1; waitLeft = DMIN + int'(rand_val); reactN = 0;
      end else if (mState == 1) begin
        if (stop && FSEN) begin
          mState = 4; reactN = 9999;
        end else if (tick) begin
          waitLeft = waitLeft - 1;
          if (waitLeft == 0) mState = 2;
        end
      end else if (mState == 2) begin
        if (stop) begin
          mState = 3;
          if (reactN < bestN && !score_clr) begin
            bestN = reactN; mNewBest = 1'b1;
          end
        end else if (tick) begin
          reactN = reactN + 1;
          if (reactN == 9999) mState = 3;
        end
      end
      if (score_clr) bestN = 9999;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_state", int'(state), mState);
      chk("model_led", int'(led), int'(ledFor(mState)));
      chk("model_react", int'(react_bcd), int'(toBcd(reactN)));
      chk("model_best", int'(best_bcd), int'(toBcd(bestN)));
      chk("model_new_best", int'(new_best), int'(mNewBest));
    end
  end

  task automatic step(input bit st, input bit sp, input bit tk, input bit clr, input bit rs);
    start = st; stop = sp; tick = tk; score_clr = clr; reset = rs;
    @(negedge clk);
    start = 0; stop = 0; tick = 0; score_clr = 0; reset = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(0, 0, 1, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; tick = 0; start = 0; stop = 0; score_clr = 0; rand_val = 16'd3;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("reset_state", int'(state), 0);
    chk("reset_led", int'(led), 'h000);
    chk("reset_react", int'(react_bcd), 'h0000);
    chk("reset_best", int'(best_bcd), 'h9999);
    chk("reset_new_best", int'(new_best), 0);

    // Round 1: tick in the start cycle is ignored; GO on the 7th tick after it
    step(1, 0, 1, 0, 0);
    chk("r1_wait", int'(state), 1);
    for (int i = 1; i <= 6; i++) begin
      ticks(1);
      chk("r1_wait_tick", int'(state), 1);
    end
    ticks(1);
    chk("r1_go_state", int'(state), 2);
    chk("r1_go_led", int'(led), 'h3FF);
    ticks(12);
    step(0, 1, 0, 0, 0);
    chk("r1_react", int'(react_bcd), 'h0012);
    chk("r1_done", int'(state), 3);
    chk("r1_done_led", int'(led), 'h001);
    chk("r1_best", int'(best_bcd), 'h0012);
    chk("r1_new_best", int'(new_best), 1);
    step(0, 0, 0, 0, 0);
    chk("r1_new_best_drop", int'(new_best), 0);

    // Round 2: slower, highscore holds
    step(1, 0, 0, 0, 0);
    ticks(7);
    ticks(15);
    step(0, 1, 0, 0, 0);
    chk("r2_react", int'(react_bcd), 'h0015);
    chk("r2_best", int'(best_bcd), 'h0012);
    chk("r2_new_best", int'(new_best), 0);

    // Stop during the wait phase
    step(1, 0, 0, 0, 0);
    ticks(2);
    step(0, 1, 0, 0, 0);
    if (FSEN) begin
      chk("fs_state", int'(state), 4);
      chk("fs_led", int'(led), 'h2AA);
      chk("fs_react", int'(react_bcd), 'h9999);
      chk("fs_best", int'(best_bcd), 'h0012);
    end else begin
      chk("fs_ignored", int'(state), 1);
      ticks(4);
      chk("fs_still_wait", int'(state), 1);
      ticks(1);
      chk("fs_go", int'(state), 2);
    end

    // Saturation run with carry checkpoint
    step(1, 0, 0, 0, 0);
    ticks(7);
    ticks(999);
    chk("sat_0999", int'(react_bcd), 'h0999);
    ticks(1);
    chk("sat_1000", int'(react_bcd), 'h1000);
    chk("sat_1000_state", int'(state), 2);
    ticks(8998);
    chk("sat_9998", int'(react_bcd), 'h9998);
    ticks(1);
    chk("sat_9999", int'(react_bcd), 'h9999);
    chk("sat_done", int'(state), 3);
    chk("sat_best", int'(best_bcd), 'h0012);
    chk("sat_new_best", int'(new_best), 0);
    step(0, 1, 1, 0, 0);
    chk("done_hold", int'(state), 3);

    // start + stop together in GO restarts the wait
    step(1, 0, 0, 0, 0);
    ticks(7);
    ticks(4);
    step(1, 1, 1, 0, 0);
    chk("ss_state", int'(state), 1);
    chk("ss_react", int'(react_bcd), 'h0000);
    ticks(7);
    chk("ss_go", int'(state), 2);
    ticks(3);
    // score_clr beats a qualifying stop
    step(0, 1, 0, 1, 0);
    chk("clr_react", int'(react_bcd), 'h0003);
    chk("clr_state", int'(state), 3);
    chk("clr_best", int'(best_bcd), 'h9999);
    chk("clr_new_best", int'(new_best), 0);

    // New best, then reset mid-GO
    step(1, 0, 0, 0, 0);
    ticks(7);
    ticks(5);
    step(0, 1, 0, 0, 0);
    chk("nb_best", int'(best_bcd), 'h0005);
    chk("nb_pulse", int'(new_best), 1);
    step(1, 0, 0, 0, 0);
    ticks(7);
    ticks(2);
    step(1, 1, 1, 0, 1);
    chk("rst_state", int'(state), 0);
    chk("rst_led", int'(led), 'h000);
    chk("rst_react", int'(react_bcd), 'h0000);
    chk("rst_best", int'(best_bcd), 'h9999);
    chk("rst_new_best", int'(new_best), 0);
    step(0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
